// File: rtl/audipus_audio_pkg.sv
// Shared audio constants and the I2S slot-position helper used by the
// receive path, AudioProcessing and the DAC transmitter.
package audipus_audio_pkg;

  localparam int I2S_SLOT_WIDTH        = 32;
  localparam int DAC_SAMPLE_WIDTH      = 24;
  localparam int I2S_CLK_DIV           = 2;
  localparam int AUDIO_CTRL_DAC_EN_BIT = 0;

  // Where a bclk period sits inside the stereo frame.
  typedef enum logic [1:0] {
    SLOT_GAP   = 2'd0,
    SLOT_LEFT  = 2'd1,
    SLOT_RIGHT = 2'd2
  } slot_phase_e;

  // Philips I2S: data starts one bclk after the lrclk change, so sample
  // bits occupy positions 1..data_w of each slot; everything else is padding.
  function automatic slot_phase_e slot_phase(input int unsigned bit_pos,
                                             input int unsigned slot_w,
                                             input int unsigned data_w);
    slot_phase_e ph;
    if ((bit_pos >= 32'd1) && (bit_pos <= data_w)) begin
      ph = SLOT_LEFT;
    end else if ((bit_pos >= slot_w + 32'd1) && (bit_pos <= slot_w + data_w)) begin
      ph = SLOT_RIGHT;
    end else begin
      ph = SLOT_GAP;
    end
    return ph;
  endfunction

endpackage

// File: rtl/i2s_tx_timing.sv
// Bit/word clock generation for the DAC transmitter: clk divider, bclk,
// lrclk, the per-frame bit counter and the falling-edge / frame-load strobes.
module i2s_tx_timing
  import audipus_audio_pkg::*;
#(
  parameter int CLK_DIV    = I2S_CLK_DIV,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int CNT_W      = $clog2(2 * SLOT_WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             bclk,
  output logic             lrclk,
  output logic             fall_evt,
  output logic             load_evt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_WIDTH);

  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic             lrclk_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             div_term_s;

  // Strobes: a falling edge is a divider wrap while bclk is high; bit_cnt
  // holds the slot position that the upcoming falling edge will present.
  always_comb begin
    div_term_s = (div_cnt_r == DIV_LAST);
    fall_evt   = reset_n & enable & div_term_s & bclk_r;
    load_evt   = fall_evt & (bit_cnt_r == {CNT_W{1'b0}});
  end

  // Divider, bclk toggle, and lrclk/bit position advance on falling edges.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (div_term_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
      end
      if (fall_evt) begin
        lrclk_r   <= (bit_cnt_r >= CNT_SLOT);
        bit_cnt_r <= (bit_cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign bclk    = bclk_r;
  assign lrclk   = lrclk_r;
  assign bit_cnt = bit_cnt_r;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the PCM1792: one-entry stereo holding buffer with a
// valid/ready handshake, L/R shift registers, serial data mux and a sticky
// underrun flag. Clocking comes from i2s_tx_timing.
module i2s_dac_tx
  import audipus_audio_pkg::*;
#(
  parameter int CLK_DIV    = I2S_CLK_DIV,
  parameter int DATA_WIDTH = DAC_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_l,
  input  logic [DATA_WIDTH-1:0] sample_r,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  dac_bclk,
  output logic                  dac_lrclk,
  output logic                  dac_data,
  output logic                  frame_start,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);

  logic                  fall_evt;
  logic                  load_evt;
  logic [CNT_W-1:0]      bit_cnt;
  slot_phase_e           phase_s;

  logic                  buf_full_r;
  logic [DATA_WIDTH-1:0] buf_l_r;
  logic [DATA_WIDTH-1:0] buf_r_r;
  logic [DATA_WIDTH-1:0] shl_r;
  logic [DATA_WIDTH-1:0] shr_r;
  logic                  ready_r;
  logic                  data_r;
  logic                  frame_start_r;
  logic                  underrun_r;

  logic                  xfer_s;
  logic                  take_s;
  logic                  set_ur_s;
  logic                  buf_full_nxt_s;
  logic                  data_nxt_s;
  logic [DATA_WIDTH-1:0] shl_nxt_s;
  logic [DATA_WIDTH-1:0] shr_nxt_s;

  i2s_tx_timing #(
    .CLK_DIV    (CLK_DIV),
    .SLOT_WIDTH (SLOT_WIDTH),
    .CNT_W      (CNT_W)
  ) u_timing (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .bclk     (dac_bclk),
    .lrclk    (dac_lrclk),
    .fall_evt (fall_evt),
    .load_evt (load_evt),
    .bit_cnt  (bit_cnt)
  );

  assign phase_s = slot_phase(32'(bit_cnt), SLOT_WIDTH, DATA_WIDTH);

  // Buffer occupancy: a transfer always fills it (even alongside an
  // empty-buffer load, whose frame goes out silent); a full load empties it.
  always_comb begin
    xfer_s   = sample_valid & ready_r;
    take_s   = load_evt & buf_full_r;
    set_ur_s = load_evt & ~buf_full_r;
    if (xfer_s) begin
      buf_full_nxt_s = 1'b1;
    end else if (take_s) begin
      buf_full_nxt_s = 1'b0;
    end else begin
      buf_full_nxt_s = buf_full_r;
    end
  end

  // Serial data: load the shift pair at frame start, shift MSB-first during
  // each slot's data window, drive zero in the padding bits.
  always_comb begin
    data_nxt_s = data_r;
    shl_nxt_s  = shl_r;
    shr_nxt_s  = shr_r;
    if (load_evt) begin
      data_nxt_s = 1'b0;
      if (take_s) begin
        shl_nxt_s = buf_l_r;
        shr_nxt_s = buf_r_r;
      end else begin
        shl_nxt_s = {DATA_WIDTH{1'b0}};
        shr_nxt_s = {DATA_WIDTH{1'b0}};
      end
    end else if (fall_evt) begin
      case (phase_s)
        SLOT_LEFT: begin
          data_nxt_s = shl_r[DATA_WIDTH-1];
          shl_nxt_s  = shl_r << 1'b1;
        end
        SLOT_RIGHT: begin
          data_nxt_s = shr_r[DATA_WIDTH-1];
          shr_nxt_s  = shr_r << 1'b1;
        end
        default: begin
          data_nxt_s = 1'b0;
        end
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // State update; disable aborts the frame like reset but keeps underrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_full_r    <= 1'b0;
      buf_l_r       <= {DATA_WIDTH{1'b0}};
      buf_r_r       <= {DATA_WIDTH{1'b0}};
      shl_r         <= {DATA_WIDTH{1'b0}};
      shr_r         <= {DATA_WIDTH{1'b0}};
      ready_r       <= 1'b0;
      data_r        <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else if (!enable) begin
      buf_full_r    <= 1'b0;
      buf_l_r       <= {DATA_WIDTH{1'b0}};
      buf_r_r       <= {DATA_WIDTH{1'b0}};
      shl_r         <= {DATA_WIDTH{1'b0}};
      shr_r         <= {DATA_WIDTH{1'b0}};
      ready_r       <= 1'b0;
      data_r        <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= underrun_r;
    end else begin
      buf_full_r    <= buf_full_nxt_s;
      if (xfer_s) begin
        buf_l_r <= sample_l;
        buf_r_r <= sample_r;
      end
      shl_r         <= shl_nxt_s;
      shr_r         <= shr_nxt_s;
      ready_r       <= ~buf_full_nxt_s;
      data_r        <= data_nxt_s;
      frame_start_r <= load_evt;
      if (set_ur_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clr) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign sample_ready = ready_r;
  assign dac_data     = data_r;
  assign frame_start  = frame_start_r;
  assign underrun     = underrun_r;

endmodule
